// File: rtl/cnn_quad_job_sequencer.sv
// Job sequencer for one cnn_layer_accel_quad: buffers descriptors, then walks each job through
// per-lane config beats, start, input-fetch servicing and a 4-phase completion handshake.
module cnn_quad_job_sequencer #(
    parameter int C_DEPTH = 4,
    parameter int C_CNT_W = 16
) (
    input  logic               clk_if,
    input  logic               rst_n,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [127:0]       desc_params,
    input  logic [127:0]       desc_cfg_data,
    input  logic [3:0]         desc_cfg_mask,
    input  logic               abort,
    output logic               job_start,
    input  logic               job_accept,
    output logic [127:0]       job_parameters,
    input  logic               job_fetch_request,
    output logic               job_fetch_ack,
    input  logic               job_fetch_complete,
    input  logic               job_complete,
    output logic               job_complete_ack,
    output logic [3:0]         config_valid,
    input  logic [3:0]         config_accept,
    output logic [127:0]       config_data,
    output logic               busy,
    output logic [C_CNT_W-1:0] jobs_done,
    output logic               err_unexpected
);

    localparam int AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(C_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_START,
        ST_FETCH,
        ST_RUN,
        ST_ACK
    } state_t;

    state_t state;

    logic [127:0] fifo_params [C_DEPTH];
    logic [127:0] fifo_cfg    [C_DEPTH];
    logic [3:0]   fifo_mask   [C_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push;
    logic          pop;
    logic [3:0]    pending;
    logic [3:0]    pending_next;

    function automatic logic [3:0] lowest_bit(input logic [3:0] m);
        return m & (~m + 4'd1);
    endfunction

    assign full         = (count == CNT_FULL);
    assign desc_ready   = !full;
    assign push         = desc_valid && desc_ready;
    assign pop          = (state == ST_IDLE) && (count != '0);
    assign busy         = (state != ST_IDLE);
    assign pending_next = pending & ~config_valid;

    // NOTE: descriptor storage has no reset; validity is tracked by count alone, so the array stays plain RAM.
    always_ff @(posedge clk_if) begin
        if (push) begin
            fifo_params[wr_ptr] <= desc_params;
            fifo_cfg[wr_ptr]    <= desc_cfg_data;
            fifo_mask[wr_ptr]   <= desc_cfg_mask;
        end
    end

    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every state and output register is assigned with <= so all updates land together at the edge.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pending          <= '0;
            job_parameters   <= '0;
            config_valid     <= '0;
            config_data      <= '0;
            job_start        <= 1'b0;
            job_fetch_ack    <= 1'b0;
            job_complete_ack <= 1'b0;
            jobs_done        <= '0;
        end else begin
            job_fetch_ack <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state            <= ST_IDLE;
                job_start        <= 1'b0;
                config_valid     <= '0;
                job_complete_ack <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (pop) begin
                            job_parameters <= fifo_params[rd_ptr];
                            config_data    <= fifo_cfg[rd_ptr];
                            pending        <= fifo_mask[rd_ptr];
                            if (fifo_mask[rd_ptr] != 4'b0) begin
                                config_valid <= lowest_bit(fifo_mask[rd_ptr]);
                                state        <= ST_CFG;
                            end else begin
                                job_start <= 1'b1;
                                state     <= ST_START;
                            end
                        end
                    end
                    ST_CFG: begin
                        // Only the accept bit of the lane currently offered counts.
                        if ((config_valid & config_accept) != 4'b0) begin
                            pending      <= pending_next;
                            config_valid <= lowest_bit(pending_next);
                            if (pending_next == 4'b0) begin
                                job_start <= 1'b1;
                                state     <= ST_START;
                            end
                        end
                    end
                    ST_START: begin
                        if (job_accept) begin
                            job_start <= 1'b0;
                            state     <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        job_fetch_ack <= job_fetch_request;
                        if (job_complete) begin
                            job_complete_ack <= 1'b1;
                            state            <= ST_ACK;
                        end else if (job_fetch_complete) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (job_complete) begin
                            job_complete_ack <= 1'b1;
                            state            <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        if (!job_complete) begin
                            job_complete_ack <= 1'b0;
                            jobs_done        <= jobs_done + 1'b1;
                            state            <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            err_unexpected <= 1'b0;
        end else if ((job_complete && (state == ST_IDLE || state == ST_CFG || state == ST_START)) ||
                     (job_fetch_request && state != ST_FETCH) ||
                     (job_accept && state != ST_START)) begin
            err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn_quad_job_sequencer.sv
// Bench for cnn_quad_job_sequencer: a quad model drives the job protocol, a scoreboard holds the
// expected config beats and job parameters, and a negedge monitor compares every handshake.
module tb_cnn_quad_job_sequencer;

    localparam int C_DEPTH = 4;
    localparam int C_CNT_W = 16;

    logic               clk_if = 1'b0;
    logic               rst_n  = 1'b0;
    logic               desc_valid = 1'b0;
    logic               desc_ready;
    logic [127:0]       desc_params = '0;
    logic [127:0]       desc_cfg_data = '0;
    logic [3:0]         desc_cfg_mask = '0;
    logic               abort = 1'b0;
    logic               job_start;
    logic               job_accept = 1'b0;
    logic [127:0]       job_parameters;
    logic               job_fetch_request = 1'b0;
    logic               job_fetch_ack;
    logic               job_fetch_complete = 1'b0;
    logic               job_complete = 1'b0;
    logic               job_complete_ack;
    logic [3:0]         config_valid;
    logic [3:0]         config_accept = '0;
    logic [127:0]       config_data;
    logic               busy;
    logic [C_CNT_W-1:0] jobs_done;
    logic               err_unexpected;

    cnn_quad_job_sequencer #(.C_DEPTH(C_DEPTH), .C_CNT_W(C_CNT_W)) dut (
        .clk_if             (clk_if),
        .rst_n              (rst_n),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_params        (desc_params),
        .desc_cfg_data      (desc_cfg_data),
        .desc_cfg_mask      (desc_cfg_mask),
        .abort              (abort),
        .job_start          (job_start),
        .job_accept         (job_accept),
        .job_parameters     (job_parameters),
        .job_fetch_request  (job_fetch_request),
        .job_fetch_ack      (job_fetch_ack),
        .job_fetch_complete (job_fetch_complete),
        .job_complete       (job_complete),
        .job_complete_ack   (job_complete_ack),
        .config_valid       (config_valid),
        .config_accept      (config_accept),
        .config_data        (config_data),
        .busy               (busy),
        .jobs_done          (jobs_done),
        .err_unexpected     (err_unexpected)
    );

    always #5 clk_if = ~clk_if;

    typedef struct {
        logic [3:0]   lane;
        logic [127:0] data;
    } cfg_beat_t;

    cfg_beat_t          cfg_q[$];
    logic [127:0]       job_q[$];
    cfg_beat_t          mon_e;
    int                 checks   = 0;
    int                 failures = 0;
    logic [C_CNT_W-1:0] exp_done = '0;
    logic               prev_req = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    // Expected behaviour of one accepted descriptor: one beat per set mask bit, lowest lane first.
    task automatic model_push(input logic [127:0] p, input logic [127:0] c, input logic [3:0] m);
        cfg_beat_t b;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                b.lane = 4'(1 << i);
                b.data = c;
                cfg_q.push_back(b);
            end
        end
        job_q.push_back(p);
    endtask

    task automatic push_desc(input logic [127:0] p, input logic [127:0] c, input logic [3:0] m);
        int n = 0;
        bit done = 1'b0;
        desc_valid    = 1'b1;
        desc_params   = p;
        desc_cfg_data = c;
        desc_cfg_mask = m;
        while (!done && n < 500) begin
            @(negedge clk_if);
            if (desc_ready) begin
                model_push(p, c, m);
                done = 1'b1;
            end
            tick();
            n++;
        end
        if (!done) check("desc_ready_timeout", desc_ready, 1'b1);
        desc_valid = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_one_job(input bit do_abort, input bit skip_fc, input int n_fetch);
        int n = 0;
        while (!job_start && n < 300) begin
            config_accept = ($urandom_range(0, 2) == 0) ? config_valid : 4'b0;
            config_accept = config_accept | (4'($urandom_range(0, 15)) & ~config_valid);
            tick();
            n++;
        end
        config_accept = 4'b0;
        check("job_start_seen", job_start, 1'b1);
        if (!job_start) return;
        repeat ($urandom_range(0, 3)) tick();
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        check("job_start_drop", job_start, 1'b0);
        repeat (n_fetch) begin
            job_fetch_request = 1'b1;
            tick();
            job_fetch_request = 1'b0;
            tick();
            repeat ($urandom_range(0, 1)) tick();
        end
        if (!skip_fc) begin
            job_fetch_complete = 1'b1;
            tick();
            job_fetch_complete = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        if (do_abort) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_busy", busy, 1'b0);
            check("abort_jobs_done", jobs_done, exp_done);
            check("abort_complete_ack", job_complete_ack, 1'b0);
            return;
        end
        job_complete = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!job_complete_ack && n < 50);
        check("complete_ack_rise", job_complete_ack, 1'b1);
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("complete_ack_hold", job_complete_ack, 1'b1);
        end
        job_complete = 1'b0;
        tick();
        check("complete_ack_fall", job_complete_ack, 1'b0);
        exp_done = exp_done + 1'b1;
        check("jobs_done", jobs_done, exp_done);
        check("busy_after_job", busy, 1'b0);
    endtask

    // Scoreboard monitor: compares each config beat and each start handshake, and the fetch ack timing.
    always @(negedge clk_if) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if ((config_valid & config_accept) != 4'b0) begin
                if (cfg_q.size() == 0) begin
                    check("cfg_beat_unexpected", config_valid, 4'b0);
                end else begin
                    mon_e = cfg_q.pop_front();
                    check("cfg_lane", config_valid, mon_e.lane);
                    check("cfg_data", config_data, mon_e.data);
                end
            end
            if (job_start && job_accept) begin
                if (job_q.size() == 0) check("start_unexpected", job_start, 1'b0);
                else check("job_parameters", job_parameters, job_q.pop_front());
            end
            if (prev_req || job_fetch_ack) check("fetch_ack", job_fetch_ack, prev_req);
            prev_req = job_fetch_request;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p;
        logic [127:0] c;
        repeat (3) @(posedge clk_if);
        @(negedge clk_if);
        rst_n = 1'b1;
        tick();

        check("rst_desc_ready", desc_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_job_start", job_start, 1'b0);
        check("rst_config_valid", config_valid, 4'b0);
        check("rst_jobs_done", jobs_done, '0);
        check("rst_err", err_unexpected, 1'b0);
        check("rst_job_parameters", job_parameters, '0);

        // Two config lanes, lowest first.
        push_desc(rand128(), rand128(), 4'b0101);
        run_one_job(1'b0, 1'b0, 1);

        // Empty mask: start follows the pop directly; three fetch requests.
        push_desc(rand128(), rand128(), 4'b0000);
        check("mask0_start_low", job_start, 1'b0);
        check("mask0_busy_low", busy, 1'b0);
        tick();
        check("mask0_start_high", job_start, 1'b1);
        check("mask0_busy_high", busy, 1'b1);
        check("mask0_no_cfg", config_valid, 4'b0);
        run_one_job(1'b0, 1'b0, 3);

        // One job in flight plus four queued fills the FIFO.
        for (int i = 0; i < 5; i++) push_desc(rand128(), rand128(), 4'($urandom_range(0, 15)));
        check("fifo_full_ready", desc_ready, 1'b0);
        desc_valid  = 1'b1;
        desc_params = rand128();
        repeat (3) tick();
        check("fifo_full_hold", desc_ready, 1'b0);
        desc_valid = 1'b0;
        for (int i = 0; i < 5; i++) run_one_job(1'b0, i == 2, $urandom_range(0, 3));

        // Abort in RUN; the queued job runs afterwards.
        push_desc(rand128(), rand128(), 4'b1000);
        push_desc(rand128(), rand128(), 4'b0110);
        run_one_job(1'b1, 1'b0, 2);
        run_one_job(1'b0, 1'b0, 1);

        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 4)) tick();
                    push_desc(rand128(), rand128(), 4'($urandom_range(0, 15)));
                end
            end
            begin
                for (int i = 0; i < 24; i++)
                    run_one_job($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
            end
        join

        repeat (5) tick();
        check("idle_busy", busy, 1'b0);
        check("cfg_q_drained", cfg_q.size(), 0);
        check("job_q_drained", job_q.size(), 0);
        check("no_err_normal", err_unexpected, 1'b0);

        // Completion while idle is a protocol error and sticks.
        job_complete = 1'b1;
        tick();
        job_complete = 1'b0;
        check("err_set", err_unexpected, 1'b1);
        repeat (3) tick();
        check("err_sticky", err_unexpected, 1'b1);
        check("err_ignored_busy", busy, 1'b0);
        check("err_ignored_done", jobs_done, exp_done);

        // Reset in the middle of a job with another descriptor waiting.
        p = rand128();
        c = rand128();
        push_desc(p, c, 4'b0000);
        tick();
        check("pre_rst_start", job_start, 1'b1);
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        job_fetch_complete = 1'b1;
        tick();
        job_fetch_complete = 1'b0;
        push_desc(rand128(), rand128(), 4'b0011);
        check("pre_rst_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_job_parameters", job_parameters, '0);
        check("mid_rst_config_data", config_data, '0);
        check("mid_rst_jobs_done", jobs_done, '0);
        check("mid_rst_err", err_unexpected, 1'b0);
        check("mid_rst_acks", {job_start, job_fetch_ack, job_complete_ack, config_valid}, '0);
        check("mid_rst_desc_ready", desc_ready, 1'b1);
        cfg_q.delete();
        job_q.delete();
        exp_done = '0;
        @(negedge clk_if);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_fifo_empty", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
